// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
// Holds the RV32I size/sign funct3 codes and the FSM state enum.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LWAIT = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Ports: funct3_i/off_i select size and lane; wdata_i -> mask_o/wdata_o
// (store path); rdata_i -> rdata_o extended load word (load path).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] bsh;
  logic [31:0] hsh;

  // Halfword and word lanes ignore the low offset bits,
  // so misaligned accesses are force-aligned here.
  assign bsh = rdata_i >> {off_i, 3'b000};
  assign hsh = rdata_i >> {off_i[1], 4'b0000};

  always_comb begin
    mask_o  = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        mask_o  = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        mask_o  = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_o = rdata_i;
    case (funct3_i)
      F3_B:  rdata_o = {{24{bsh[7]}}, bsh[7:0]};
      F3_BU: rdata_o = {24'h0, bsh[7:0]};
      F3_H:  rdata_o = {{16{hsh[15]}}, hsh[15:0]};
      F3_HU: rdata_o = {16'h0, hsh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: one-at-a-time load/store unit driving a word-aligned data memory.
// Ports: req_* request handshake in, resp_* result handshake out,
// mem_* memory port (enables only asserted in ISSUE, never in reset).
// Option: define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wr_mask_o,
  output logic        mem_wen_o,
  output logic        mem_ren_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_t  state_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_err_q;

  logic        err_d;
  logic        issue;
  logic [3:0]  mask_w;
  logic [31:0] swdata_w;
  logic [31:0] ldata_w;

  always_comb begin
    err_d = (req_funct3_i == 3'b011)
          | (req_funct3_i[2:1] == 2'b11)
          | (req_store_i & req_funct3_i[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3_i == F3_H || req_funct3_i == F3_HU)
        && req_addr_i[0])
      err_d = 1'b1;
    if (req_funct3_i == F3_W && req_addr_i[1:0] != 2'b00)
      err_d = 1'b1;
`endif
  end

  lsu_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata_i),
    .mask_o   (mask_w),
    .wdata_o  (swdata_w),
    .rdata_o  (ldata_w)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rd_q        <= 5'h0;
      resp_data_q <= 32'h0;
      resp_rd_q   <= 5'h0;
      resp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            store_q <= req_store_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_i;
            if (err_d) begin
              resp_err_q  <= 1'b1;
              resp_rd_q   <= req_rd_i;
              resp_data_q <= 32'h0;
              state_q     <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (store_q) begin
            resp_data_q <= 32'h0;
            resp_rd_q   <= rd_q;
            resp_err_q  <= 1'b0;
            state_q     <= RESP;
          end else begin
            state_q <= LWAIT;
          end
        end
        LWAIT: begin
          resp_data_q <= ldata_w;
          resp_rd_q   <= rd_q;
          resp_err_q  <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_data_q <= 32'h0;
            resp_rd_q   <= 5'h0;
            resp_err_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue         = (state_q == ISSUE);
  assign req_ready_o   = (state_q == IDLE);
  assign resp_valid_o  = (state_q == RESP);
  assign resp_data_o   = resp_data_q;
  assign resp_rd_o     = resp_rd_q;
  assign resp_err_o    = resp_err_q;

  assign mem_addr_o    = issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wr_mask_o = (issue & store_q) ? mask_w : 4'h0;
  assign mem_wdata_o   = (issue & store_q) ? swdata_w : 32'h0;
  // Enables drop in a reset cycle so an aborted store never writes.
  assign mem_wen_o     = issue & store_q & ~rst_i;
  assign mem_ren_o     = issue & ~store_q & ~rst_i;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a small registered-read memory.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:15] = '{32'h80ABCD12, 32'h11223344,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0};
  int en_cnt = 0;
  int vec = 0;
  int errs = 0;
  int en_snap;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_store_i   (req_store),
    .req_funct3_i  (req_funct3),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_rd_i      (req_rd),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_data_o   (resp_data),
    .resp_rd_o     (resp_rd),
    .resp_err_o    (resp_err),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wr_mask_o (mem_mask),
    .mem_wen_o     (mem_wen),
    .mem_ren_o     (mem_ren),
    .mem_rdata_i   (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b])
          mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren) mem_rdata <= mem[mem_addr[5:2]];
    if (mem_wen | mem_ren) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns mid-cycle 1.
  task automatic send(input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] rd);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] exp_data,
                         input logic [31:0] exp_maddr);
    send(1'b0, f3, a, 32'h0, rd);
    chk({tag, " c1 ren"}, mem_ren, 1);
    chk({tag, " c1 maddr"}, mem_addr, exp_maddr);
    chk({tag, " c1 valid"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, " c2 ren"}, mem_ren, 0);
    chk({tag, " c2 valid"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, " c3 valid"}, resp_valid, 1);
    chk({tag, " data"}, resp_data, exp_data);
    chk({tag, " rd"}, resp_rd, rd);
    chk({tag, " err"}, resp_err, 0);
    @(negedge clk);
    chk({tag, " idle"}, req_ready, 1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] exp_mask,
                          input logic [31:0] exp_wd);
    send(1'b1, f3, a, wd, 5'd2);
    chk({tag, " c1 wen"}, mem_wen, 1);
    chk({tag, " c1 maddr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, " c1 mask"}, mem_mask, exp_mask);
    chk({tag, " c1 wdata"}, mem_wdata, exp_wd);
    @(negedge clk);
    chk({tag, " c2 wen"}, mem_wen, 0);
    chk({tag, " c2 valid"}, resp_valid, 1);
    chk({tag, " c2 data"}, resp_data, 0);
    chk({tag, " c2 rd"}, resp_rd, 2);
    @(negedge clk);
  endtask

  task automatic do_err(input string tag, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [4:0] rd);
    en_snap = en_cnt;
    send(st, f3, a, 32'h12345678, rd);
    chk({tag, " c1 valid"}, resp_valid, 1);
    chk({tag, " c1 err"}, resp_err, 1);
    chk({tag, " c1 data"}, resp_data, 0);
    chk({tag, " c1 rd"}, resp_rd, rd);
    chk({tag, " c1 ren"}, mem_ren, 0);
    chk({tag, " c1 wen"}, mem_wen, 0);
    @(negedge clk);
    chk({tag, " no access"}, en_cnt, en_snap);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " req_ready"}, req_ready, 1);
    chk({tag, " resp_valid"}, resp_valid, 0);
    chk({tag, " resp_err"}, resp_err, 0);
    chk({tag, " resp_data"}, resp_data, 0);
    chk({tag, " resp_rd"}, resp_rd, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " mem_mask"}, mem_mask, 0);
    chk({tag, " mem_wen"}, mem_wen, 0);
    chk({tag, " mem_ren"}, mem_ren, 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'h0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outs("reset");
    @(negedge clk);

    do_load("LB3",  3'b000, 32'h80000003, 5'd5,  32'hFFFFFF80, 32'h80000000);
    do_load("LBU3", 3'b100, 32'h80000003, 5'd6,  32'h00000080, 32'h80000000);
    do_load("LH2",  3'b001, 32'h80000002, 5'd7,  32'hFFFF80AB, 32'h80000000);
    do_load("LHU0", 3'b101, 32'h80000000, 5'd8,  32'h0000CD12, 32'h80000000);

`ifdef LSU_MISALIGN_TRAP_EN
    do_err("LW6", 1'b0, 3'b010, 32'h80000006, 5'd10);
`else
    do_load("LW6",  3'b010, 32'h80000006, 5'd10, 32'h11223344, 32'h80000004);
`endif

    do_store("SB2", 3'b000, 32'h80000002, 32'h000000A5,
             4'b0100, 32'hA5A5A5A5);
    chk("SB2 mem", mem[0], 32'h80A5CD12);
    do_store("SH2", 3'b001, 32'h80000006, 32'h1234BEEF,
             4'b1100, 32'hBEEFBEEF);
    chk("SH2 mem", mem[1], 32'hBEEF3344);

    // Backpressure: hold writeback off for 5 cycles.
    resp_ready = 1'b0;
    send(1'b0, 3'b010, 32'h80000000, 32'h0, 5'd9);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", resp_valid, 1);
      chk("bp data", resp_data, 32'h80A5CD12);
      chk("bp rd", resp_rd, 9);
      chk("bp err", resp_err, 0);
      chk("bp req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp idle ready", req_ready, 1);
    chk("bp idle valid", resp_valid, 0);
    // Back-to-back requests right after the handshake.
    do_err("F3_011", 1'b0, 3'b011, 32'h80000000, 5'd3);
    do_err("SB_F3_100", 1'b1, 3'b100, 32'h80000001, 5'd4);
    do_err("F3_111", 1'b0, 3'b111, 32'h80000004, 5'd11);

    // Reset during ISSUE of a word store.
    en_snap = en_cnt;
    send(1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 5'd12);
    chk("rstSW pre wen", mem_wen, 1);
    rst = 1'b1;
    #1;
    chk("rstSW wen", mem_wen, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstSW mem", mem[1], 32'hBEEF3344);
    chk("rstSW no access", en_cnt, en_snap);
    chk_reset_outs("rstSW");
    @(negedge clk);

    do_load("LHU2 after rst", 3'b101, 32'h80000006, 5'd13,
            32'h0000BEEF, 32'h80000004);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
